inst_fetch_unit: RTL and testbench

Initiator side of the instruction-memory interface. Owns the fetch PC and drives the byte address to the combinational, big-endian, 32-bit-wide instruction memory. Captures each returned word into a small instruction queue and hands instructions to the decode stage over a valid/ready handshake. Handles PC increment, branch/jump redirect with queue flush, and decode back-pressure.

---
 rtl/inst_fetch_unit.sv | 73 +++++++
 tb/tb_inst_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, instruction queue and decode handshake; IFETCH_ALIGN_CHECK_EN adds misaligned-redirect trap
module inst_fetch_unit #(
  parameter int PCL = 32,
  parameter int DEPTH = 2,
  parameter logic [PCL-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP = 32'b00000100000000000000000000000000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [PCL-1:0]             imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [PCL-1:0]             redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_out,
  output logic [PCL-1:0]             pc_out,
  output logic [PCL-1:0]             pc4_out,
  output logic [$clog2(DEPTH):0]     q_count
`ifdef IFETCH_ALIGN_CHECK_EN
  ,output logic                      misalign_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [PCL-1:0] fetch_pc, target;
  logic [PCL-1:0] q_pc [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  logic err, bad, push, pop;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign bad = redirect_pc[1:0] != 2'b00;
  assign target = {redirect_pc[PCL-1:2], 2'b00};
  assign misalign_err = err;
`else
  assign bad = 1'b0;
  assign target = redirect_pc;
`endif
  assign imem_addr = fetch_pc;
  assign inst_valid = count != '0;
  assign pop = inst_valid && inst_ready;
  // err freezes fetch until reset; it can only become set in the align-check build
  assign push = !redirect && !err && (count < FULL || pop);
  assign inst_out = inst_valid ? q_inst[rptr] : NOP;
  assign pc_out = inst_valid ? q_pc[rptr] : '0;
  assign pc4_out = inst_valid ? q_pc[rptr] + PCL'(4) : '0;
  assign q_count = count;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= target;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      err <= err | bad;
    end else begin
      if (push) begin
        q_pc[wptr] <= fetch_pc;
        q_inst[wptr] <= imem_data;
        wptr <= wptr + 1'b1;
        fetch_pc <= fetch_pc + PCL'(4);
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch stream, back-pressure, redirect, wrap and reset
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'b00000100000000000000000000000000;
  logic clk = 0, rst = 1, redirect = 0, inst_ready = 1, inst_valid;
  logic [31:0] imem_addr, imem_data, redirect_pc = 0, inst_out, pc_out, pc4_out;
  logic [1:0] q_count;
  int checks = 0, errors = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_err;
`endif
  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out),
    .pc4_out(pc4_out), .q_count(q_count)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  assign imem_data = word(imem_addr);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; redirect = 0;
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; inst_ready = 1;
    tick(); tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_out, NOP); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc_out); end
    checks++; if (pc4_out !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", pc4_out); end
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", q_count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    rst = 0;
  endtask
  task automatic test_stream();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (pc_out !== 32'(4*k)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, pc_out, 32'(4*k)); end
      checks++; if (inst_out !== word(32'(4*k))) begin errors++; $display("FAIL stream_inst[%0d] got %h exp %h", k, inst_out, word(32'(4*k))); end
      checks++; if (pc4_out !== 32'(4*k+4)) begin errors++; $display("FAIL stream_pc4[%0d] got %h exp %h", k, pc4_out, 32'(4*k+4)); end
      checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", k, q_count); end
    end
  endtask
  task automatic test_backpressure();
    inst_ready = 0;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", q_count); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr got %h exp 8", imem_addr); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL bp_hold_pc got %h exp 0", pc_out); end
    inst_ready = 1;
    for (int k = 1; k < 3; k++) begin
      tick();
      checks++; if (pc_out !== 32'(4*k)) begin errors++; $display("FAIL bp_seq[%0d] got %h exp %h", k, pc_out, 32'(4*k)); end
      checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL bp_seq_count[%0d] got %0d exp 2", k, q_count); end
    end
  endtask
  task automatic test_redirect();
    inst_ready = 0;
    do_reset();
    tick(); tick();
    redirect = 1; redirect_pc = 32'h40;
    tick();
    redirect = 0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", inst_valid); end
    checks++; if (inst_out !== NOP) begin errors++; $display("FAIL redir_inst got %h exp %h", inst_out, NOP); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp 40", imem_addr); end
    tick();
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp 40", pc_out); end
    checks++; if (pc4_out !== 32'h44) begin errors++; $display("FAIL redir_pc4 got %h exp 44", pc4_out); end
    checks++; if (inst_out !== word(32'h40)) begin errors++; $display("FAIL redir_word got %h exp %h", inst_out, word(32'h40)); end
    tick();
    checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL redir_full got %0d exp 2", q_count); end
    redirect = 1; redirect_pc = 32'h100; inst_ready = 1;
    tick();
    redirect = 0;
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL redir_pop_count got %0d exp 0", q_count); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_pop_valid got %b exp 0", inst_valid); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (pc_out !== 32'(32'h100 + 4*k)) begin errors++; $display("FAIL redir_pop_seq[%0d] got %h exp %h", k, pc_out, 32'(32'h100 + 4*k)); end
    end
  endtask
  task automatic test_wrap();
    inst_ready = 1;
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
    checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", pc_out); end
    checks++; if (pc4_out !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc4_out); end
    checks++; if (inst_out !== word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_inst got %h exp %h", inst_out, word(32'hFFFF_FFFC)); end
    tick();
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", pc_out); end
  endtask
  task automatic test_reset_mid();
    inst_ready = 0;
    tick(); tick();
    rst = 1; redirect = 1; redirect_pc = 32'h80;
    tick();
    rst = 0; redirect = 0;
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", q_count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_addr got %h exp 0", imem_addr); end
    tick();
    checks++; if (pc_out !== 32'h0 || inst_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_first got %h/%b exp 0/1", pc_out, inst_valid); end
  endtask
`ifdef IFETCH_ALIGN_CHECK_EN
  task automatic test_misalign();
    inst_ready = 1;
    do_reset();
    tick();
    redirect = 1; redirect_pc = 32'h42;
    tick();
    redirect = 0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", misalign_err); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL mis_addr got %h exp 40", imem_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b0 || inst_out !== NOP) begin errors++; $display("FAIL mis_stall[%0d] got %b/%h exp 0/%h", k, inst_valid, inst_out, NOP); end
    end
    do_reset();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misalign_err); end
  endtask
`endif
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
`ifdef IFETCH_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
